// File: rtl/integral_window_ctrl.sv
// integral_window_ctrl
// Accepts a raster pixel stream and forwards each frame pixel to a row-chain
// FIFO. Each forwarded pixel is tagged with its column and line. The block
// also flags the pixels where a full WINDOW_SIZE x WINDOW_SIZE detection
// window ends.
//
// Ports:
//   clk_os          sole clock, rising edge
//   reset_os        synchronous active-high reset
//   i_pixel         incoming pixel
//   i_pixel_valid   i_pixel valid this cycle
//   i_frame_start   marks i_pixel as pixel (0,0) of a new frame
//   i_stall         back-pressure from the row chain
//   o_ready         block accepts a pixel this cycle
//   o_wen           write enable to the row chain (one cycle per pixel)
//   o_fifo_in       pixel to the row chain
//   o_col / o_row   coordinates of the pixel on o_fifo_in
//   o_window_valid  a full window ends at (o_row, o_col)
//   o_frame_done    coincides with the o_wen of the last frame pixel
module integral_window_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int WINDOW_SIZE  = 24
) (
  input  logic                  clk_os,
  input  logic                  reset_os,
  input  logic [DATA_WIDTH-1:0] i_pixel,
  input  logic                  i_pixel_valid,
  input  logic                  i_frame_start,
  input  logic                  i_stall,
  output logic                  o_ready,
  output logic                  o_wen,
  output logic [DATA_WIDTH-1:0] o_fifo_in,
  output logic [9:0]            o_col,
  output logic [8:0]            o_row,
  output logic                  o_window_valid,
  output logic                  o_frame_done
);

  localparam int COL_W = (FRAME_WIDTH  > 1) ? $clog2(FRAME_WIDTH)  : 1;
  localparam int ROW_W = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;

  localparam logic [COL_W-1:0] COL_LAST   = COL_W'(FRAME_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(FRAME_HEIGHT - 1);
  localparam logic [COL_W-1:0] WIN_COL_LO = COL_W'(WINDOW_SIZE - 1);
  localparam logic [ROW_W-1:0] WIN_ROW_LO = ROW_W'(WINDOW_SIZE - 1);

  typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;

  state_t                  state_q, state_d;
  logic [COL_W-1:0]        col_q, col_d;
  logic [ROW_W-1:0]        row_q, row_d;
  logic                    wen_q, wen_d;
  logic [DATA_WIDTH-1:0]   fifo_in_q, fifo_in_d;
  logic [9:0]              col_out_q, col_out_d;
  logic [8:0]              row_out_q, row_out_d;
  logic                    window_valid_q, window_valid_d;
  logic                    frame_done_q, frame_done_d;

  logic                    accept;
  logic                    take;
  logic                    last_pix;
  logic [COL_W-1:0]        pix_col;
  logic [ROW_W-1:0]        pix_row;

  // DONE is the single cycle in which no pixel is taken. Everywhere else the
  // block is ready unless the row chain pushes back.
  assign o_ready = (state_q != DONE) && !i_stall;
  assign accept  = i_pixel_valid && o_ready;

  // Next-state logic. col_q/row_q hold the coordinates of the next pixel to
  // be accepted. pix_col/pix_row are the coordinates assigned to the pixel
  // accepted this cycle. A frame_start always forces that pixel to (0,0),
  // so it also aborts a frame in progress.
  always_comb begin
    state_d        = state_q;
    col_d          = col_q;
    row_d          = row_q;
    wen_d          = 1'b0;
    fifo_in_d      = fifo_in_q;
    col_out_d      = col_out_q;
    row_out_d      = row_out_q;
    window_valid_d = 1'b0;
    frame_done_d   = 1'b0;
    take           = 1'b0;
    last_pix       = 1'b0;
    pix_col        = '0;
    pix_row        = '0;

    case (state_q)
      IDLE: begin
        if (accept && i_frame_start) begin
          take    = 1'b1;
          state_d = FILL;
        end
      end
      FILL, RUN: begin
        if (accept) begin
          take = 1'b1;
          if (i_frame_start) begin
            state_d = FILL;
          end else begin
            pix_col = col_q;
            pix_row = row_q;
            if (row_q == ROW_LAST && col_q == COL_LAST) begin
              last_pix     = 1'b1;
              state_d      = DONE;
              frame_done_d = 1'b1;
            end else if (state_q == FILL && row_q == WIN_ROW_LO && col_q == WIN_COL_LO) begin
              state_d = RUN;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (take) begin
      wen_d          = 1'b1;
      fifo_in_d      = i_pixel;
      col_out_d      = 10'(pix_col);
      row_out_d      = 9'(pix_row);
      window_valid_d = (pix_row >= WIN_ROW_LO) && (pix_col >= WIN_COL_LO);
      if (last_pix) begin
        col_d = '0;
        row_d = '0;
      end else if (pix_col == COL_LAST) begin
        col_d = '0;
        row_d = pix_row + ROW_W'(1);
      end else begin
        col_d = pix_col + COL_W'(1);
        row_d = pix_row;
      end
    end
  end

  // State, counter and output registers. Reset takes priority over
  // everything, including a stalled or mid-frame cycle.
  always_ff @(posedge clk_os) begin
    if (reset_os) begin
      state_q        <= IDLE;
      col_q          <= '0;
      row_q          <= '0;
      wen_q          <= 1'b0;
      fifo_in_q      <= '0;
      col_out_q      <= '0;
      row_out_q      <= '0;
      window_valid_q <= 1'b0;
      frame_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      col_q          <= col_d;
      row_q          <= row_d;
      wen_q          <= wen_d;
      fifo_in_q      <= fifo_in_d;
      col_out_q      <= col_out_d;
      row_out_q      <= row_out_d;
      window_valid_q <= window_valid_d;
      frame_done_q   <= frame_done_d;
    end
  end

  assign o_wen          = wen_q;
  assign o_fifo_in      = fifo_in_q;
  assign o_col          = col_out_q;
  assign o_row          = row_out_q;
  assign o_window_valid = window_valid_q;
  assign o_frame_done   = frame_done_q;

endmodule
